tsmux_logger: RTL and testbench
===============================

TSMUX_LOGGER -- requirements
Module: tsmux_logger

Interface
REQ-001 Parameter NCH, default 4: number of input channels, 1..16.
REQ-002 Parameter CW, default 56: timestamp width in bits.
REQ-003 Parameter AW, default 4: FIFO address width; depth = 2**AW records.
REQ-004 Derived constant CHW = max(1, clog2(NCH)); record width RW = CW + CHW + 1.
REQ-005 clk  in  1  counter and FIFO clock; all logic on posedge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 datain  in  NCH  unsynchronised event inputs, bit i = channel i.
REQ-008 edgemode  in  2*NCH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-009 counterin  in  CW  free-running timestamp.
REQ-010 pop  in  1  removes the oldest FIFO record.
REQ-011 clearoverrun  in  NCH  per-channel overrun clear.
REQ-012 dataout  out  RW  oldest record {timestamp, channel id, level}; level in bit 0.
REQ-013 empty  out  1  FIFO holds no records.
REQ-014 fill  out  AW+1  number of records in the FIFO.
REQ-015 overrun  out  NCH  sticky per-channel event-loss flags.
REQ-016 attention  out  1  registered service request.

Function
REQ-017 Each channel SHALL pass datain through two flip-flops; the second-stage output is the synced level.
REQ-018 Each channel SHALL hold last, its previously accepted synced level.
REQ-019 An edge is detected on a cycle where synced level != last; last updates to the synced level in that same cycle regardless of mode.
REQ-020 The edge SHALL qualify as an event when mode is 01 and the new level is 1, mode 10 and the new level is 0, or mode 11.
REQ-021 After reset release, a start-up counter SHALL run to 7 and then saturate.
REQ-022 On the 5th clock edge after reset release, every channel whose mode is not 00 SHALL generate one initial-state event with its current synced level.
REQ-023 No edge detection SHALL occur until the start-up counter reaches 7; last SHALL track the synced level until then.
REQ-024 Each channel SHALL have a one-deep pending register holding {counterin, level}; counterin is sampled on the detection edge.
REQ-025 An event arriving while pending is occupied and not granted in that cycle SHALL be dropped, pending SHALL be kept unchanged, and overrun[i] SHALL be set.
REQ-026 If pending is granted in the same cycle as a new event on that channel, the new event SHALL load and no overrun is flagged.
REQ-027 The arbiter SHALL be round-robin with pointer reset value 0. Each cycle a write is possible (not full, or pop asserted), it SHALL grant the first pending channel at or after the pointer, wrapping.
REQ-028 After a grant, the arbiter pointer SHALL become (grant+1) mod NCH; with no grant it is unchanged.
REQ-029 A granted record {ts, channel index, level} SHALL be written to the FIFO at that clock edge, and its pending register cleared.
REQ-030 At most one record SHALL be written per cycle.
REQ-031 The FIFO SHALL be show-ahead: dataout always shows the oldest record, and is don't-care when empty.
REQ-032 pop while empty SHALL be ignored.
REQ-033 A simultaneous write and pop SHALL leave fill unchanged, including when the FIFO is full.
REQ-034 Read and write pointers SHALL wrap modulo 2**AW.
REQ-035 clearoverrun[i] SHALL take priority over a same-cycle set of overrun[i].
REQ-036 attention SHALL be a register loaded each cycle with (~empty | (|overrun)), so it lags one cycle.
REQ-037 Channels with mode 00 SHALL never set pending or overrun.
REQ-038 A mode change takes effect on the next detected edge; an occupied pending register is unaffected.

Reset
REQ-039 While rst is high, all of the following SHALL hold: synchronisers, last, pending, start-up counter, arbiter pointer, FIFO pointers and overrun are 0; empty=1; fill=0; attention=0.
REQ-040 Assertion of rst mid-operation SHALL discard all queued and pending records immediately; the start-up sequence restarts on release.

Verification
REQ-041 Case: NCH=4, all modes 11, datain=4'b0101, rst released. Required: 4 initial records in channel order 0..3 with levels 1,0,1,0; fill reaches 4; attention rises one cycle after empty falls.
REQ-042 Case: ch2 mode 01, datain[2] rises 0->1 at cycle T with counterin=T. Required: one record {T+2, 2, 1}, where T+2 is the detection cycle. A later 1->0 produces no record.
REQ-043 Case: channels 0 and 3 detect events in the same cycle, pointer=1. Required: ch3 is written first, then ch0; pointer ends at 1.
REQ-044 Case: AW=2, FIFO filled to 4, ch1 produces 2 events while full. Required: the first event is held in pending; the second sets overrun[1]. After one pop, the held record enters and fill=4. clearoverrun[1] clears the flag.
REQ-045 Case: full FIFO with pop and a grant in the same cycle. Required: fill stays 4; the oldest record leaves and the new record is appended.
REQ-046 Case: rst asserted with fill=3 and pending records present. Required: empty=1, fill=0, overrun=0 asynchronously. After release, only the initial-state records appear.

Source files
------------

// File: rtl/tsmux_logger.sv
// Multi-channel edge timestamp logger: synchronised event inputs are timestamped, parked in
// per-channel pending slots and funnelled by a round-robin arbiter into a show-ahead FIFO.
module tsmux_logger #(
    parameter  int NCH = 4,
    parameter  int CW  = 56,
    parameter  int AW  = 4,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int RW  = CW + CHW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     datain,
    input  logic [2*NCH-1:0]   edgemode,
    input  logic [CW-1:0]      counterin,
    input  logic               pop,
    input  logic [NCH-1:0]     clearoverrun,
    output logic [RW-1:0]      dataout,
    output logic               empty,
    output logic [AW:0]        fill,
    output logic [NCH-1:0]     overrun,
    output logic               attention
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    function automatic logic [CHW-1:0] wrap_add(input logic [CHW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NCH) s = s - NCH;
        return CHW'(s);
    endfunction

    logic [NCH-1:0] sync1, sync2, last;
    logic [2:0]     startup;
    logic           init_edge, detect_en;
    logic [NCH-1:0] event_hit;

    logic [NCH-1:0] pend_valid;
    logic [CW:0]    pend_data [NCH];   // {timestamp, level}

    logic           wr_ok, grant_valid;
    logic [CHW-1:0] grant_idx, rr_ptr;
    logic [NCH-1:0] grant_hot, ovr_set;

    logic [RW-1:0]  mem [2**AW];
    logic [AW-1:0]  wptr, rptr;
    logic [AW:0]    count;
    logic           full, do_wr, do_rd;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, exactly like the hardware it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            last    <= '0;
            startup <= '0;
        end else begin
            sync1 <= datain;
            sync2 <= sync1;
            last  <= sync2;
            if (startup != 3'd7) startup <= startup + 3'd1;
        end
    end

    // Startup value 4 is the 5th edge after release; edges are only watched once saturated.
    assign init_edge = (startup == 3'd4);
    assign detect_en = (startup == 3'd7);

    // NOTE: every always_comb output gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        event_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            if (init_edge) begin
                event_hit[i] = (edgemode[2*i +: 2] != 2'b00);
            end else if (detect_en && (sync2[i] != last[i])) begin
                case (edgemode[2*i +: 2])
                    2'b01:   event_hit[i] = sync2[i];
                    2'b10:   event_hit[i] = ~sync2[i];
                    2'b11:   event_hit[i] = 1'b1;
                    default: event_hit[i] = 1'b0;
                endcase
            end
        end
    end

    assign full  = (count == DEPTH);
    assign empty = (count == '0);
    assign fill  = count;
    assign wr_ok = ~full | pop;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_hot   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (wr_ok && pend_valid[wrap_add(rr_ptr, k)]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_add(rr_ptr, k);
            end
        end
        if (grant_valid) grant_hot[grant_idx] = 1'b1;
    end

    assign ovr_set = event_hit & pend_valid & ~grant_hot;
    assign do_wr   = grant_valid;
    assign do_rd   = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= '0;
            for (int i = 0; i < NCH; i++) pend_data[i] <= '0;
            rr_ptr     <= '0;
            overrun    <= '0;
            attention  <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                // A slot being drained this cycle can accept the new event directly.
                if (grant_hot[i]) begin
                    pend_valid[i] <= event_hit[i];
                    if (event_hit[i]) pend_data[i] <= {counterin, sync2[i]};
                end else if (event_hit[i] && !pend_valid[i]) begin
                    pend_valid[i] <= 1'b1;
                    pend_data[i]  <= {counterin, sync2[i]};
                end
            end
            if (grant_valid) rr_ptr <= wrap_add(grant_idx, 1);
            overrun   <= (overrun | ovr_set) & ~clearoverrun;
            attention <= ~empty | (|overrun);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and count define
    // which entries are valid, so clearing the contents would only cost logic.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= {pend_data[grant_idx][CW:1], grant_idx, pend_data[grant_idx][0]};
    end

    assign dataout = mem[rptr];

endmodule

// File: tb/tb_tsmux_logger.sv
// Bench for tsmux_logger: edge-mode vector table, directed arbitration/FIFO/reset sequences
// and randomized traffic, all scored every cycle against a queue-based reference model.
module tb_tsmux_logger;
    localparam int NCH   = 4;
    localparam int CW    = 16;
    localparam int AW    = 2;
    localparam int CHW   = 2;
    localparam int RW    = CW + CHW + 1;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   datain;
    logic [2*NCH-1:0] edgemode;
    logic [CW-1:0]    counterin;
    logic             pop;
    logic [NCH-1:0]   clearoverrun;
    logic [RW-1:0]    dataout;
    logic             empty;
    logic [AW:0]      fill;
    logic [NCH-1:0]   overrun;
    logic             attention;

    tsmux_logger #(.NCH(NCH), .CW(CW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .datain(datain), .edgemode(edgemode), .counterin(counterin),
        .pop(pop), .clearoverrun(clearoverrun), .dataout(dataout), .empty(empty),
        .fill(fill), .overrun(overrun), .attention(attention)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: pipeline of observed levels, pending slots, a queue for the FIFO.
    logic [NCH-1:0] m_s1, m_s2, m_last, m_pv, m_plvl, m_ovr;
    logic [CW-1:0]  m_pts [NCH];
    int             m_since, m_ptr;
    logic           m_att;
    logic [RW-1:0]  m_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_last = '0; m_pv = '0; m_plvl = '0; m_ovr = '0;
        for (int i = 0; i < NCH; i++) m_pts[i] = '0;
        m_since = 0; m_ptr = 0; m_att = 1'b0;
        m_q.delete();
    endtask

    task automatic model_step();
        int             grant;
        logic [NCH-1:0] ev;
        logic [1:0]     md;
        bit             rd, can_write;
        if (rst) begin
            model_reset();
            return;
        end
        rd        = pop && (m_q.size() > 0);
        can_write = (m_q.size() < DEPTH) || pop;
        grant     = -1;
        if (can_write) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (grant < 0 && m_pv[c]) grant = c;
            end
        end
        ev = '0;
        for (int i = 0; i < NCH; i++) begin
            md = edgemode[2*i +: 2];
            if (md != 2'b00) begin
                if (m_since == 4) ev[i] = 1'b1;
                else if (m_since >= 7 && m_s2[i] != m_last[i])
                    ev[i] = (md == 2'b11) || (md == 2'b01 && m_s2[i]) || (md == 2'b10 && !m_s2[i]);
            end
        end
        m_att = (m_q.size() != 0) || (m_ovr != '0);
        for (int i = 0; i < NCH; i++) begin
            if (ev[i] && m_pv[i] && grant != i) m_ovr[i] = 1'b1;
            if (clearoverrun[i]) m_ovr[i] = 1'b0;
        end
        if (rd) void'(m_q.pop_front());
        if (grant >= 0) begin
            m_q.push_back({m_pts[grant], CHW'(grant), m_plvl[grant]});
            m_pv[grant] = 1'b0;
            m_ptr = (grant + 1) % NCH;
        end
        for (int i = 0; i < NCH; i++) begin
            if (ev[i] && !m_pv[i]) begin
                m_pv[i]   = 1'b1;
                m_pts[i]  = counterin;
                m_plvl[i] = m_s2[i];
            end
        end
        m_last = m_s2;
        m_s2   = m_s1;
        m_s1   = datain;
        if (m_since < 100) m_since++;
    endtask

    task automatic compare_all();
        check("model empty", 64'(empty), 64'(m_q.size() == 0));
        check("model fill", 64'(fill), 64'(m_q.size()));
        check("model overrun", 64'(overrun), 64'(m_ovr));
        check("model attention", 64'(attention), 64'(m_att));
        if (m_q.size() > 0) check("model dataout", 64'(dataout), 64'(m_q[0]));
    endtask

    // Inputs are changed only at the falling edge, so DUT and model sample the same values.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        counterin = counterin + 1'b1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_pop();
        pop = 1'b1;
        cycle();
        pop = 1'b0;
    endtask

    task automatic check_head(input string name, input int ch, input logic lvl);
        check({name, " ch"}, 64'(dataout[1 +: CHW]), 64'(ch));
        check({name, " lvl"}, 64'(dataout[0]), 64'(lvl));
    endtask

    task automatic apply_reset(input int hold);
        rst = 1'b1;
        model_reset();
        #1;
        check("reset empty", 64'(empty), 64'd1);
        check("reset fill", 64'(fill), 64'd0);
        check("reset overrun", 64'(overrun), 64'd0);
        check("reset attention", 64'(attention), 64'd0);
        tick(hold);
        rst = 1'b0;
    endtask

    typedef struct {
        int         ch;
        logic [1:0] mode;
        logic       from_lvl;
        logic       to_lvl;
        int         exp_fill;
    } vec_t;

    vec_t          vecs [8];
    logic [CW-1:0] t0;
    int            exp_ch  [4];
    logic          exp_lvl [4];
    int            pop_pct;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2, 2'b01, 1'b0, 1'b1, 1};
        vecs[1] = '{2, 2'b01, 1'b1, 1'b0, 0};
        vecs[2] = '{1, 2'b10, 1'b1, 1'b0, 1};
        vecs[3] = '{1, 2'b10, 1'b0, 1'b1, 0};
        vecs[4] = '{3, 2'b11, 1'b0, 1'b1, 1};
        vecs[5] = '{3, 2'b11, 1'b1, 1'b0, 1};
        vecs[6] = '{0, 2'b00, 1'b0, 1'b1, 0};
        vecs[7] = '{0, 2'b00, 1'b1, 1'b0, 0};

        datain = 4'b0101; edgemode = 8'hFF; counterin = '0; pop = 1'b0; clearoverrun = '0;
        apply_reset(2);

        // Initial-state records after release.
        tick(5);
        check("init before 6th edge fill", 64'(fill), 64'd0);
        tick(1);
        check("init first fill", 64'(fill), 64'd1);
        check("init first empty", 64'(empty), 64'd0);
        check("init attention lags", 64'(attention), 64'd0);
        tick(1);
        check("init attention rises", 64'(attention), 64'd1);
        tick(2);
        check("init fill 4", 64'(fill), 64'd4);
        exp_lvl = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            check_head($sformatf("init rec%0d", k), k, exp_lvl[k]);
            do_pop();
        end
        check("init drained", 64'(empty), 64'd1);

        // Edge-mode vector table.
        for (int v = 0; v < 8; v++) begin
            edgemode = '0;
            datain[vecs[v].ch] = vecs[v].from_lvl;
            tick(4);
            edgemode[2*vecs[v].ch +: 2] = vecs[v].mode;
            tick(1);
            t0 = counterin;
            datain[vecs[v].ch] = vecs[v].to_lvl;
            tick(4);
            check($sformatf("vec%0d fill", v), 64'(fill), 64'(vecs[v].exp_fill));
            if (vecs[v].exp_fill == 1) begin
                check($sformatf("vec%0d ts", v), 64'(dataout[RW-1 -: CW]), 64'(CW'(t0 + 16'd2)));
                check_head($sformatf("vec%0d", v), vecs[v].ch, vecs[v].to_lvl);
            end
            do_pop();
            tick(1);
        end

        // Round-robin: pointer at 1, channels 0 and 3 fire together.
        edgemode = '0; datain = '0; tick(4);
        edgemode = 8'b11000011; tick(1);
        datain[0] = 1'b1; tick(4);
        check("rr setup fill", 64'(fill), 64'd1);
        do_pop();
        datain = 4'b1000; tick(5);
        check("rr fill 2", 64'(fill), 64'd2);
        check_head("rr first", 3, 1'b1);
        do_pop();
        check_head("rr second", 0, 1'b0);
        do_pop();
        check("rr drained", 64'(empty), 64'd1);
        datain = 4'b0001; tick(5);
        check_head("rr pointer kept", 3, 1'b0);
        do_pop(); do_pop(); tick(1);

        // Full FIFO, held pending, overrun, pop with simultaneous grant, clear.
        edgemode = '0; datain = '0; tick(4);
        edgemode = 8'b00001111; tick(1);
        for (int k = 0; k < 4; k++) begin
            datain[0] = ~datain[0];
            tick(2);
        end
        tick(4);
        check("full fill", 64'(fill), 64'd4);
        datain[1] = 1'b1; tick(3);
        check("held no overrun", 64'(overrun), 64'd0);
        datain[1] = 1'b0; tick(3);
        check("dropped sets overrun", 64'(overrun), 64'b0010);
        check("full still 4", 64'(fill), 64'd4);
        do_pop();
        check("pop+grant fill", 64'(fill), 64'd4);
        check_head("pop+grant head", 0, 1'b0);
        clearoverrun = 4'b0010; cycle(); clearoverrun = '0;
        check("overrun cleared", 64'(overrun), 64'd0);
        exp_ch  = '{0, 0, 0, 1};
        exp_lvl = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            check_head($sformatf("full drain%0d", k), exp_ch[k], exp_lvl[k]);
            do_pop();
        end
        check("full drained", 64'(empty), 64'd1);

        // Reset mid-operation with queued and pending records and an overrun.
        edgemode = '0; datain = '0; tick(4);
        edgemode = 8'hFF; tick(1);
        datain = 4'b0001; tick(4);
        check("pre-reset fill 1", 64'(fill), 64'd1);
        datain = 4'b1110; tick(1);
        datain = 4'b1111; tick(4);
        check("pre-reset fill 3", 64'(fill), 64'd3);
        check("pre-reset overrun", 64'(overrun), 64'b0001);
        apply_reset(2);
        tick(9);
        check("post-reset fill", 64'(fill), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check_head($sformatf("post-reset rec%0d", k), k, 1'b1);
            do_pop();
        end
        tick(3);
        check("post-reset only init", 64'(empty), 64'd1);

        // Randomized traffic with varying drain rates.
        pop_pct = 25;
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) pop_pct = $urandom_range(5, 90);
            datain = datain ^ (4'($urandom()) & 4'($urandom()) & 4'($urandom()));
            if ($urandom_range(0, 63) == 0) edgemode = 8'($urandom());
            pop = ($urandom_range(0, 99) < pop_pct);
            clearoverrun = ($urandom_range(0, 15) == 0) ? 4'($urandom()) : 4'b0000;
            if ($urandom_range(0, 999) == 0) apply_reset(1);
            cycle();
        end
        pop = 1'b0; clearoverrun = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
